// File: rtl/program_loader.sv
// program_loader: byte-stream writer for the core's writable program memory.
// Accepts a length byte N, then N big-endian 16-bit words over a valid/ready
// byte interface, and writes them to program-memory addresses 0..N-1. The core
// is held in reset until a load completes cleanly.
//
// Optional feature macro: CHECKSUM_EN
//   defined   - a trailing checksum byte (XOR of N and all data bytes) must
//               match, otherwise the load ends in error.
//   undefined - no checksum byte; the last low byte completes the load.
//
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   start_i        single-cycle pulse that begins a load (ignored while busy)
//   in_valid_i     in_data_i holds a valid byte
//   in_data_i      stream byte
//   in_ready_o     loader accepts a byte this cycle
//   pm_we_o        program-memory write strobe, one cycle per word
//   pm_addr_o      program-memory write address
//   pm_wdata_o     program-memory write data
//   core_reset_o   holds the core in reset (1 = hold)
//   busy_o         load in progress
//   done_o         last load completed without error
//   error_o        last load aborted
module program_loader #(
    parameter int unsigned PC_WIDTH = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start_i,
    input  logic                in_valid_i,
    input  logic [7:0]          in_data_i,
    output logic                in_ready_o,
    output logic                pm_we_o,
    output logic [PC_WIDTH-1:0] pm_addr_o,
    output logic [15:0]         pm_wdata_o,
    output logic                core_reset_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                error_o
);

    // The top address is the core's halt slot, so at most DEPTH-1 words load.
    localparam int unsigned DEPTH = 32'd1 << PC_WIDTH;
    localparam int unsigned MAXW  = ((DEPTH - 32'd1) > 32'd255) ? 32'd255 : (DEPTH - 32'd1);

`ifdef CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_HI, S_LO, S_CHK, S_DONE, S_ERROR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_HI, S_LO, S_DONE, S_ERROR
    } state_t;
`endif

    state_t                state_q;
    logic [PC_WIDTH-1:0]   addr_q;
    logic [7:0]            cnt_q;
    logic [7:0]            hi_q;
`ifdef CHECKSUM_EN
    logic [7:0]            ck_q;
`endif

    logic                  in_ready_q;
    logic                  pm_we_q;
    logic [PC_WIDTH-1:0]   pm_addr_q;
    logic [15:0]           pm_wdata_q;
    logic                  core_reset_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;

    logic                  accept_c;
    logic                  restart_c;
    logic                  len_bad_c;

    // Handshake, start qualification and length validation.
    assign accept_c  = in_valid_i & in_ready_q;
    assign restart_c = start_i & ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                  (state_q == S_ERROR));
    assign len_bad_c = (in_data_i == 8'd0) || (32'(in_data_i) > MAXW);

    // Loader FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            cnt_q        <= 8'd0;
            hi_q         <= 8'd0;
`ifdef CHECKSUM_EN
            ck_q         <= 8'd0;
`endif
            in_ready_q   <= 1'b0;
            pm_we_q      <= 1'b0;
            pm_addr_q    <= '0;
            pm_wdata_q   <= 16'd0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            pm_we_q <= 1'b0;

            case (state_q)
                S_LEN: begin
                    if (accept_c) begin
                        if (len_bad_c) begin
                            state_q    <= S_ERROR;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                        end else begin
                            state_q <= S_HI;
                            cnt_q   <= in_data_i;
`ifdef CHECKSUM_EN
                            ck_q    <= in_data_i;
`endif
                        end
                    end
                end

                S_HI: begin
                    if (accept_c) begin
                        state_q <= S_LO;
                        hi_q    <= in_data_i;
`ifdef CHECKSUM_EN
                        ck_q    <= ck_q ^ in_data_i;
`endif
                    end
                end

                S_LO: begin
                    if (accept_c) begin
                        pm_we_q    <= 1'b1;
                        pm_addr_q  <= addr_q;
                        pm_wdata_q <= {hi_q, in_data_i};
                        addr_q     <= addr_q + PC_WIDTH'(1);
                        cnt_q      <= cnt_q - 8'd1;
`ifdef CHECKSUM_EN
                        ck_q       <= ck_q ^ in_data_i;
`endif
                        if (cnt_q == 8'd1) begin
`ifdef CHECKSUM_EN
                            state_q    <= S_CHK;
`else
                            state_q    <= S_DONE;
                            in_ready_q <= 1'b0;
`endif
                        end else begin
                            state_q <= S_HI;
                        end
                    end
                end

`ifdef CHECKSUM_EN
                S_CHK: begin
                    if (accept_c) begin
                        in_ready_q <= 1'b0;
                        if (in_data_i == ck_q) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_ERROR;
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
                        end
                    end
                end
`endif

                // Status flips one cycle after entry, i.e. after the final write lands.
                S_DONE: begin
                    busy_q       <= 1'b0;
                    done_q       <= 1'b1;
                    core_reset_q <= 1'b0;
                end

                default: ;
            endcase

            // A qualified start overrides whatever the idle/terminal state set above.
            if (restart_c) begin
                state_q      <= S_LEN;
                addr_q       <= '0;
                in_ready_q   <= 1'b1;
                core_reset_q <= 1'b1;
                busy_q       <= 1'b1;
                done_q       <= 1'b0;
                error_q      <= 1'b0;
`ifdef CHECKSUM_EN
                ck_q         <= 8'd0;
`endif
            end
        end
    end

    assign in_ready_o   = in_ready_q;
    assign pm_we_o      = pm_we_q;
    assign pm_addr_o    = pm_addr_q;
    assign pm_wdata_o   = pm_wdata_q;
    assign core_reset_o = core_reset_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = error_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed bench for program_loader with PC_WIDTH=6.
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// too, before the next change. Program-memory writes are logged on the
// falling edge and compared against the expected word list.
module tb_program_loader;

    localparam int unsigned PCW = 6;

    logic           clock;
    logic           reset;
    logic           start;
    logic           in_valid;
    logic [7:0]     in_data;
    logic           in_ready;
    logic           pm_we;
    logic [PCW-1:0] pm_addr;
    logic [15:0]    pm_wdata;
    logic           core_reset;
    logic           busy;
    logic           done;
    logic           error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [PCW-1:0] wr_addr[$];
    logic [15:0]    wr_data[$];
    logic [15:0]    words_q[$];
    logic [7:0]     tb_xor;
    bit             start_during;

    program_loader #(.PC_WIDTH(PCW)) dut (
        .clock        (clock),
        .reset        (reset),
        .start_i      (start),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_ready_o   (in_ready),
        .pm_we_o      (pm_we),
        .pm_addr_o    (pm_addr),
        .pm_wdata_o   (pm_wdata),
        .core_reset_o (core_reset),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Write logger.
    always @(negedge clock) begin
        if (pm_we) begin
            wr_addr.push_back(pm_addr);
            wr_data.push_back(pm_wdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic got;
        got = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 20; i++) begin
            got = in_ready;
            tick();
            if (got) break;
        end
        in_valid = 1'b0;
        if (!got) check_eq("handshake_timeout", 32'd0, 32'd1);
    endtask

    // Sends N and all words in words_q; optional idle cycle before each byte.
    task automatic stream(input bit gap);
        int n;
        n = words_q.size();
        tb_xor = 8'(n);
        if (gap) tick();
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            tb_xor = tb_xor ^ words_q[i][15:8] ^ words_q[i][7:0];
            start = start_during;
            if (gap) tick();
            send_byte(words_q[i][15:8]);
            if (gap) tick();
            send_byte(words_q[i][7:0]);
        end
        start = 1'b0;
    endtask

    task automatic finish_ok(input string tag);
`ifdef CHECKSUM_EN
        send_byte(tb_xor);
`endif
        check_eq({tag, "_done_early"}, 32'(done), 32'd0);
        tick();
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_core_reset"}, 32'(core_reset), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_error"}, 32'(error), 32'd0);
    endtask

    task automatic verify_writes(input string tag);
        check_eq({tag, "_nwrites"}, 32'(wr_addr.size()), 32'(words_q.size()));
        for (int i = 0; i < words_q.size() && i < wr_addr.size(); i++) begin
            check_eq($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[i]), 32'(i));
            check_eq($sformatf("%s_data%0d", tag, i), 32'(wr_data[i]), 32'(words_q[i]));
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        words_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'd0;
        start_during = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset values.
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_pm_we", 32'(pm_we), 32'd0);
        check_eq("rst_pm_addr", 32'(pm_addr), 32'd0);
        check_eq("rst_pm_wdata", 32'(pm_wdata), 32'd0);
        check_eq("rst_core_reset", 32'(core_reset), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);

        // 1: two words back-to-back.
        clear_log();
        pulse_start();
        check_eq("t1_busy", 32'(busy), 32'd1);
        check_eq("t1_in_ready", 32'(in_ready), 32'd1);
        check_eq("t1_core_reset", 32'(core_reset), 32'd1);
        words_q.push_back(16'h1234);
        words_q.push_back(16'hB105);
        stream(1'b0);
        check_eq("t1_last_we", 32'(pm_we), 32'd1);
        check_eq("t1_last_addr", 32'(pm_addr), 32'd1);
        check_eq("t1_last_data", 32'(pm_wdata), 32'hB105);
        finish_ok("t1");
        verify_writes("t1");
        tick();
        tick();
        check_eq("t1_hold_addr", 32'(pm_addr), 32'd1);
        check_eq("t1_hold_data", 32'(pm_wdata), 32'hB105);
        check_eq("t1_hold_we", 32'(pm_we), 32'd0);

        // 2: illegal lengths 0 and 64.
        clear_log();
        pulse_start();
        check_eq("t2_core_reset_restart", 32'(core_reset), 32'd1);
        send_byte(8'd0);
        check_eq("t2_n0_error", 32'(error), 32'd1);
        check_eq("t2_n0_busy", 32'(busy), 32'd0);
        check_eq("t2_n0_in_ready", 32'(in_ready), 32'd0);
        check_eq("t2_n0_core_reset", 32'(core_reset), 32'd1);
        pulse_start();
        check_eq("t2_restart_error", 32'(error), 32'd0);
        check_eq("t2_restart_busy", 32'(busy), 32'd1);
        send_byte(8'd64);
        check_eq("t2_n64_error", 32'(error), 32'd1);
        check_eq("t2_n64_core_reset", 32'(core_reset), 32'd1);
        tick();
        tick();
        check_eq("t2_nwrites", 32'(wr_addr.size()), 32'd0);
        check_eq("t2_done", 32'(done), 32'd0);

        // 3: maximum length, in_valid toggling.
        clear_log();
        pulse_start();
        for (int i = 0; i < 63; i++) words_q.push_back({8'(i) ^ 8'hA5, 8'(i)});
        stream(1'b1);
        finish_ok("t3");
        verify_writes("t3");

        // 4: reset after 3 of 5 words, then N=1 reload.
        clear_log();
        pulse_start();
        send_byte(8'd5);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h40);
            send_byte(8'(i));
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("t4_busy", 32'(busy), 32'd0);
        check_eq("t4_core_reset", 32'(core_reset), 32'd1);
        check_eq("t4_in_ready", 32'(in_ready), 32'd0);
        check_eq("t4_pm_addr", 32'(pm_addr), 32'd0);
        check_eq("t4_partial_writes", 32'(wr_addr.size()), 32'd3);
        clear_log();
        pulse_start();
        words_q.push_back(16'hBEEF);
        stream(1'b0);
        finish_ok("t4");
        verify_writes("t4");

        // 5: in_valid while idle and start pulses mid-load are ignored.
        clear_log();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b1;
        in_data = 8'd3;
        tick();
        tick();
        tick();
        check_eq("t5_idle_in_ready", 32'(in_ready), 32'd0);
        check_eq("t5_idle_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
        pulse_start();
        words_q.push_back(16'h0102);
        words_q.push_back(16'h0304);
        start_during = 1'b1;
        stream(1'b0);
        start_during = 1'b0;
        finish_ok("t5");
        verify_writes("t5");

`ifdef CHECKSUM_EN
        // 6: checksum accept and reject.
        clear_log();
        pulse_start();
        send_byte(8'd1);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h27);
        tick();
        check_eq("t6_good_done", 32'(done), 32'd1);
        check_eq("t6_good_error", 32'(error), 32'd0);
        pulse_start();
        send_byte(8'd1);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h00);
        check_eq("t6_bad_error", 32'(error), 32'd1);
        check_eq("t6_bad_core_reset", 32'(core_reset), 32'd1);
        tick();
        check_eq("t6_bad_done", 32'(done), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
